// File: rtl/epsilon_greedy_selector.sv
// Epsilon-greedy action selector: argmax over streamed Q-values, or a random action when a random draw falls below epsilon.
// Optional epsilon decay on episode completion is enabled by defining EPSILON_DECAY_EN.
module epsilon_greedy_selector #(
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter logic [7:0]  EPS_INIT    = 8'd255,
  parameter logic [7:0]  EPS_MIN     = 8'd13,
  parameter logic [7:0]  EPS_STEP    = 8'd1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic                           i_q_valid,
  input  logic [DATA_WIDTH-1:0]          i_q_data,
  input  logic [7:0]                     i_random_data,
  output logic                           o_random_enable,
  input  logic                           i_episode_done,
  output logic [$clog2(NUM_ACTIONS)-1:0] o_action,
  output logic                           o_action_valid,
  output logic                           o_explored,
  output logic                           o_busy,
  output logic [7:0]                     o_epsilon
);

  localparam int unsigned AW = $clog2(NUM_ACTIONS);

  typedef enum logic [2:0] {IDLE, DRAW_E, DRAW_A, COLLECT, DECIDE} state_t;

  state_t                        state, state_next;
  logic [AW-1:0]                 idx;
  logic signed [DATA_WIDTH-1:0]  max_val;
  logic [AW-1:0]                 arg_idx;
  logic [7:0]                    r_explore;
  logic [AW-1:0]                 r_rand_act;
  logic                          first_collect;
  logic [AW-1:0]                 action_q;
  logic                          explored_q;
  logic                          explore;
  logic [AW-1:0]                 dec_action;
  logic                          last_beat;
  logic [7:0]                    epsilon;

  assign last_beat = (state == COLLECT) && i_q_valid && (idx == AW'(NUM_ACTIONS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = DRAW_E;
      DRAW_E:  state_next = DRAW_A;
      DRAW_A:  state_next = COLLECT;
      COLLECT: if (last_beat) state_next = DECIDE;
      DECIDE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decision is formed combinationally in DECIDE so it sees the pre-decay epsilon
  always_comb begin
    explore    = (r_explore < epsilon);
    dec_action = explore ? r_rand_act : arg_idx;
  end

  always_comb begin
    o_random_enable = 1'b0;
    o_action_valid  = 1'b0;
    o_busy          = (state != IDLE);
    o_action        = action_q;
    o_explored      = explored_q;
    case (state)
      DRAW_E, DRAW_A: o_random_enable = 1'b1;
      DECIDE: begin
        o_action_valid = 1'b1;
        o_action       = dec_action;
        o_explored     = explore;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      max_val       <= '0;
      arg_idx       <= '0;
      r_explore     <= '0;
      r_rand_act    <= '0;
      first_collect <= 1'b0;
      action_q      <= '0;
      explored_q    <= 1'b0;
    end else begin
      first_collect <= (state == DRAW_A);
      if (state == DRAW_A) r_explore <= i_random_data;
      if (state == COLLECT && first_collect) r_rand_act <= i_random_data[AW-1:0];
      if (state == COLLECT && i_q_valid) begin
        // Strict compare keeps the lowest index on ties
        if (idx == '0 || $signed(i_q_data) > max_val) begin
          max_val <= $signed(i_q_data);
          arg_idx <= idx;
        end
        idx <= idx + 1'b1;
      end
      if (state == DECIDE) begin
        action_q   <= dec_action;
        explored_q <= explore;
      end
    end
  end

`ifdef EPSILON_DECAY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      epsilon <= EPS_INIT;
    else if (i_episode_done)
      epsilon <= ({1'b0, epsilon} >= ({1'b0, EPS_MIN} + {1'b0, EPS_STEP})) ? epsilon - EPS_STEP : EPS_MIN;
  end
`else
  logic unused_decay;
  assign epsilon      = EPS_INIT;
  assign unused_decay = ^{i_episode_done, EPS_MIN, EPS_STEP};
`endif

  assign o_epsilon = epsilon;

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
// Directed scoreboard bench for epsilon_greedy_selector; tracks EPSILON_DECAY_EN to model epsilon.
module tb_epsilon_greedy_selector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_q_valid = 1'b0;
  logic [15:0] i_q_data = '0;
  logic [7:0]  i_random_data = '0;
  logic        o_random_enable;
  logic        i_episode_done = 1'b0;
  logic [1:0]  o_action;
  logic        o_action_valid;
  logic        o_explored;
  logic        o_busy;
  logic [7:0]  o_epsilon;

  typedef struct {
    logic [1:0] action;
    logic       explored;
    int         cycle;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rnd_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] eps_exp = 8'd255;

  epsilon_greedy_selector #(
    .NUM_ACTIONS(4),
    .DATA_WIDTH(16),
    .EPS_INIT(8'd255),
    .EPS_MIN(8'd13),
    .EPS_STEP(8'd1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_q_valid(i_q_valid),
    .i_q_data(i_q_data),
    .i_random_data(i_random_data),
    .o_random_enable(o_random_enable),
    .i_episode_done(i_episode_done),
    .o_action(o_action),
    .o_action_valid(o_action_valid),
    .o_explored(o_explored),
    .o_busy(o_busy),
    .o_epsilon(o_epsilon)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] eps_dec(input logic [7:0] e);
`ifdef EPSILON_DECAY_EN
    return (e > 8'd13) ? e - 8'd1 : 8'd13;
`else
    return e;
`endif
  endfunction

  // Random source: advances one edge after an enable is seen
  initial forever begin
    @(negedge clk);
    if (o_random_enable === 1'b1) begin
      @(posedge clk);
      #1;
      if (rnd_q.size() > 0) i_random_data = rnd_q.pop_front();
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (o_action_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, o_action_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("action", {30'd0, o_action}, {30'd0, e.action});
        check("explored", {31'd0, o_explored}, {31'd0, e.explored});
        if (e.cycle >= 0) check("latency", cyc, e.cycle);
      end
    end
  end

  task automatic pulse_eps(input int n);
    for (int i = 0; i < n; i++) begin
      i_episode_done = 1'b1;
      eps_exp = eps_dec(eps_exp);
      @(negedge clk);
      i_episode_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_decision(input logic [7:0] expl, input logic [7:0] act_raw,
                              input logic signed [15:0] q [4],
                              input bit gap, input bit noise, input bit ep_at_decide);
    logic [1:0]        arg;
    logic signed [15:0] mx;
    logic              explore;
    logic [1:0]        act;
    int                t;
    arg = 2'd0;
    mx  = q[0];
    for (int i = 1; i < 4; i++) begin
      if (q[i] > mx) begin
        mx  = q[i];
        arg = 2'(i);
      end
    end
    explore = (expl < eps_exp);
    act     = explore ? act_raw[1:0] : arg;
    rnd_q.push_back(expl);
    rnd_q.push_back(act_raw);
    t = cyc;
    exp_q.push_back('{act, explore, gap ? -1 : t + 7});
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("rand_en_draw_e", {31'd0, o_random_enable}, 32'd1);
    check("busy_draw_e", {31'd0, o_busy}, 32'd1);
    if (noise) begin
      i_q_valid = 1'b1;
      i_q_data  = 16'h7fff;
    end
    @(negedge clk);
    if (noise) i_start = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
    i_q_valid = 1'b0;
    check("rand_en_collect", {31'd0, o_random_enable}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) begin
        i_q_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
      i_q_valid = 1'b1;
      i_q_data  = q[i];
      @(negedge clk);
    end
    i_q_valid = 1'b0;
    if (ep_at_decide) begin
      i_episode_done = 1'b1;
      eps_exp = eps_dec(eps_exp);
    end
    @(negedge clk);
    i_episode_done = 1'b0;
    check("action_held", {30'd0, o_action}, {30'd0, act});
    check("valid_one_cycle", {31'd0, o_action_valid}, 32'd0);
    check("idle_after", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_epsilon", {24'd0, o_epsilon}, 32'd255);
    check("rst_action", {30'd0, o_action}, 32'd0);
    check("rst_valid", {31'd0, o_action_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_rand_en", {31'd0, o_random_enable}, 32'd0);
    check("rst_explored", {31'd0, o_explored}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    pulse_eps(155);
    check("eps_after_155", {24'd0, o_epsilon}, {24'd0, eps_exp});

    run_decision(8'd200, 8'd1, '{16'sd5, -16'sd3, 16'sd40, 16'sd7}, 1'b0, 1'b1, 1'b0);
    run_decision(8'd99, 8'd2, '{16'sd0, 16'sd1, 16'sd2, 16'sd3}, 1'b0, 1'b0, 1'b1);
    check("eps_after_decide_decay", {24'd0, o_epsilon}, {24'd0, eps_exp});
    run_decision(8'd28, 8'd15, '{16'sd0, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0, 1'b0);
    run_decision(8'd255, 8'd1, '{16'sd9, 16'sd9, -16'sd1, 16'sd9}, 1'b0, 1'b0, 1'b0);
    run_decision(8'd255, 8'd0, '{-16'sd8, -16'sd2, -16'sd5, -16'sd20}, 1'b1, 1'b0, 1'b0);

    pulse_eps(94);
    check("eps_after_250", {24'd0, o_epsilon}, {24'd0, eps_exp});
    run_decision(8'd12, 8'd2, '{16'sd1, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0, 1'b1);
    check("eps_floor_held", {24'd0, o_epsilon}, {24'd0, eps_exp});

    // Abort mid-collection with reset
    rnd_q.push_back(8'd0);
    rnd_q.push_back(8'd0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_q_valid = 1'b1;
    i_q_data  = 16'd50;
    @(negedge clk);
    i_q_data  = 16'd60;
    @(negedge clk);
    i_q_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    eps_exp = 8'd255;
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_valid", {31'd0, o_action_valid}, 32'd0);
    check("abort_epsilon", {24'd0, o_epsilon}, {24'd0, eps_exp});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", {31'd0, o_busy}, 32'd0);
    run_decision(8'd255, 8'd0, '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("pending_decisions", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
